// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-serial, big-endian load/store sequencer for a byte-wide data RAM,
// arbitrating round-robin between the MEM-stage CPU port and debug word reads.
module data_mem_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 12,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic [1:0]         i_cpu_size,
  input  logic               i_cpu_unsigned,
  input  logic [NB_ADDR-1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0] i_cpu_wdata,
  output logic [NB_DATA-1:0] o_cpu_rdata,
  output logic               o_cpu_done,
  output logic               o_cpu_err,
  output logic               o_cpu_stall,
  input  logic               i_dbg_req,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_rdata,
  output logic               o_dbg_done,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_addr,
  output logic [NB_BYTE-1:0] o_ram_wdata,
  input  logic [NB_BYTE-1:0] i_ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q;
  logic [1:0] cnt_q, last_q, nm1;
  logic dbg_q, last_dbg_q, we_q, uns_q, cpu_done_q, dbg_done_q, cpu_err_q;
  logic gnt, gnt_dbg, misal;
  logic [NB_ADDR-1:0] addr_q, base;
  logic [NB_DATA-NB_BYTE-1:0] shift_q;
  logic [NB_DATA-1:0] wdata_q, wdata_al, cpu_rdata_q, dbg_rdata_q, word, res;
  assign gnt = i_cpu_req | i_dbg_req;
  assign gnt_dbg = i_dbg_req & (~i_cpu_req | ~last_dbg_q);
  assign nm1 = gnt_dbg ? 2'd3 : i_cpu_size == 2'b00 ? 2'd0 : i_cpu_size == 2'b01 ? 2'd1 : 2'd3;
  assign misal = ~gnt_dbg & ((nm1 == 2'd1 & i_cpu_addr[0]) | (nm1 == 2'd3 & |i_cpu_addr[1:0]));
  assign base = gnt_dbg ? i_dbg_addr & ~NB_ADDR'(3) : i_cpu_addr;
  // store data is left-aligned so the RAM byte always comes from the top of wdata_q
  assign wdata_al = i_cpu_wdata << {~nm1, 3'b000};
  assign word = {shift_q, i_ram_rdata};
  assign res = we_q ? '0 :
               last_q == 2'd0 ? {{(NB_DATA-NB_BYTE){~uns_q & word[NB_BYTE-1]}}, word[NB_BYTE-1:0]} :
               last_q == 2'd1 ? {{(NB_DATA-2*NB_BYTE){~uns_q & word[2*NB_BYTE-1]}}, word[2*NB_BYTE-1:0]} :
               word;
  assign o_ram_we = state_q == ACCESS & we_q;
  assign o_ram_addr = state_q == ACCESS ? addr_q + NB_ADDR'(cnt_q) : addr_q;
  assign o_ram_wdata = wdata_q[NB_DATA-1 -: NB_BYTE];
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_cpu_done = cpu_done_q;
  assign o_cpu_err = cpu_err_q;
  assign o_cpu_stall = i_cpu_req & ~cpu_done_q;
  assign o_dbg_rdata = dbg_rdata_q;
  assign o_dbg_done = dbg_done_q;
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= '0;
      dbg_q <= 1'b0;
      last_dbg_q <= 1'b1;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      shift_q <= '0;
      cpu_done_q <= 1'b0;
      cpu_err_q <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_done_q <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt) begin
          dbg_q <= gnt_dbg;
          addr_q <= base;
          we_q <= ~gnt_dbg & i_cpu_we;
          uns_q <= i_cpu_unsigned;
          last_q <= nm1;
          wdata_q <= wdata_al;
          cnt_q <= '0;
          state_q <= misal ? DONE : ACCESS;
          cpu_done_q <= misal;
          cpu_err_q <= misal;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 2'd1;
          wdata_q <= wdata_q << NB_BYTE;
          shift_q <= word[NB_DATA-NB_BYTE-1:0];
          if (cnt_q == last_q) begin
            state_q <= DONE;
            dbg_done_q <= dbg_q;
            cpu_done_q <= ~dbg_q;
            dbg_rdata_q <= dbg_q ? res : '0;
            cpu_rdata_q <= dbg_q ? '0 : res;
          end
        end
        DONE: begin
          state_q <= IDLE;
          last_dbg_q <= dbg_q;
          cpu_done_q <= 1'b0;
          cpu_err_q <= 1'b0;
          cpu_rdata_q <= '0;
          dbg_done_q <= 1'b0;
          dbg_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sequencing and arbitration controller for the byte-wide data memory in the MIPS MEM stage.
- Breaks CPU loads/stores (byte/half/word, signed/unsigned) into one-byte RAM accesses per cycle, big-endian.
- Shares the RAM between the pipeline MEM stage and the debug unit (word reads for memory dump).
- Provides stall, done and misalignment-error signalling.

Parameters:
NB_DATA, 32, CPU/debug data word width
NB_ADDR, 12, byte address width of the RAM
NB_BYTE, 8, RAM data width

Ports:
clk  in  1  system clock, all state on rising edge
i_rst  in  1  asynchronous active-high reset
i_cpu_req  in  1  MEM-stage access request, held until o_cpu_done
i_cpu_we  in  1  1 = store, 0 = load
i_cpu_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
i_cpu_unsigned  in  1  1 = zero-extend load (LBU/LHU)
i_cpu_addr  in  NB_ADDR  byte address
i_cpu_wdata  in  NB_DATA  store data, right-aligned
o_cpu_rdata  out  NB_DATA  load result, valid while o_cpu_done=1
o_cpu_done  out  1  one-cycle completion pulse
o_cpu_err  out  1  misaligned access, pulses with o_cpu_done
o_cpu_stall  out  1  i_cpu_req & ~o_cpu_done (combinational)
i_dbg_req  in  1  debug word-read request, held until o_dbg_done
i_dbg_addr  in  NB_ADDR  word-aligned byte address (bits[1:0] ignored, forced 00)
o_dbg_rdata  out  NB_DATA  read word, valid while o_dbg_done=1
o_dbg_done  out  1  one-cycle completion pulse
o_ram_we  out  1  RAM byte write enable
o_ram_addr  out  NB_ADDR  RAM byte address
o_ram_wdata  out  NB_BYTE  RAM write byte
i_ram_rdata  in  NB_BYTE  RAM read byte, asynchronous (same-cycle)

Behaviour:
- Reset (async, immediate): FSM=IDLE, byte counter=0, last-grant=DBG (so CPU wins first tie), all registered outputs 0; o_ram_we=0 immediately. An access in flight is abandoned; no partial completion is signalled.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Only one request pending: grant it.
  - Both pending: round-robin against last-grant.
  - On grant: latch requester, address, size, we, unsigned and wdata; N = 1/2/4 bytes (debug always 4, read); go to ACCESS.
  - CPU misaligned (half with addr[0]=1, word with addr[1:0]!=0): no RAM cycle; go directly to DONE with err=1 and rdata=0.
- ACCESS, cycle k = 0..N-1:
  - o_ram_addr = base+k.
  - Store: o_ram_we=1, o_ram_wdata = byte (N-1-k) of right-aligned wdata, MSB first.
  - Load: o_ram_we=0; capture i_ram_rdata into a shift register the same cycle.
  - After k=N-1 go to DONE.
- DONE:
  - Pulse the granted requester's done for exactly one cycle.
  - Load result: word = 4 bytes concatenated; half = 16 bits sign- or zero-extended per unsigned flag; byte = 8 bits extended likewise. Store result: rdata=0.
  - Update last-grant and return to IDLE.
- Latency: grant cycle + N ACCESS cycles + DONE, i.e. done is asserted N+1 cycles after the IDLE cycle that saw the request. Misaligned access: 1 cycle.
- Back-to-back: a request still high in the cycle after DONE is treated as a new access. Requesters must drop req in the cycle done is seen.
- Request inputs changing or dropping mid-access are ignored; latched values are used.
- Address wrap: base+k wraps modulo 2^NB_ADDR.
- o_ram_we is 0 in IDLE and DONE. Outside ACCESS, o_ram_addr holds the latched base.
- Non-granted done, err and rdata outputs stay 0.

Test Plan:
- Aligned word store then load: SW 0xDEADBEEF @0x010 -> RAM[0x10..0x13] = DE,AD,BE,EF; LW @0x010 -> rdata=0xDEADBEEF; done 5 cycles after request.
- Byte/half extension with RAM[0x20..0x21]=0x80,0x7F: LB @0x20 -> 0xFFFFFF80; LBU -> 0x00000080; LH -> 0xFFFF807F; LHU -> 0x0000807F.
- Misalignment: LW @0x011 -> err=1, rdata=0, done 1 cycle after request, no o_ram_we pulse, RAM unchanged; SH @0x013 -> err=1.
- Arbitration: CPU and debug request together from reset -> CPU served first, then debug. Both held again -> alternating grants. Debug read @0x013 returns the word at 0x010.
- Reset mid-store: assert i_rst during the 2nd ACCESS cycle of SW @0x040 -> o_ram_we drops immediately, no done pulse, only RAM[0x40] written. After release, the next request is serviced normally.
- Wrap: SW 0x11223344 @0xFFC -> bytes land at 0xFFC..0xFFF, RAM[0x000] untouched; SH at last half @0xFFE -> 0xFFE..0xFFF.
